// File: rtl/reg_file_mp_if.sv
// ---------------------------------------------------------------------------
// reg_file_mp_if
// Bus bundle between a core's decode/writeback logic and the multi-port
// register file.
//   clear_req  master->slave  one-cycle request to zero the whole file
//   ready      slave->master  1 = file usable, 0 while a clear runs
//   we0/wn0/wd0               write port 0 (lower priority)
//   we1/wn1/wd1               write port 1 (higher priority)
//   rn         master->slave  packed read addresses, port k = rn[k*ADDR_W +: ADDR_W]
//   rd         slave->master  packed read data,      port k = rd[k*DATA_W +: DATA_W]
// ---------------------------------------------------------------------------
interface reg_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
);
   logic                  clear_req;
   logic                  ready;
   logic                  we0;
   logic [ADDR_W-1:0]     wn0;
   logic [DATA_W-1:0]     wd0;
   logic                  we1;
   logic [ADDR_W-1:0]     wn1;
   logic [DATA_W-1:0]     wd1;
   logic [NRD*ADDR_W-1:0] rn;
   logic [NRD*DATA_W-1:0] rd;

   modport master (
      output clear_req, we0, wn0, wd0, we1, wn1, wd1, rn,
      input  ready, rd
   );

   modport slave (
      input  clear_req, we0, wn0, wd0, we1, wn1, wd1, rn,
      output ready, rd
   );
endinterface

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Parametrised multi-port register file: NRD combinational read ports, two
// write ports (port 1 wins on an address collision), entry 0 reads as zero.
// After reset, or on clear_req, a sequencer zeroes entries 1..2**ADDR_W-1 one
// per cycle; during that time writes are ignored and every read returns 0.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (restarts the clear sequence)
//   bus    reg_file_mp_if.slave (clear_req/ready, write ports, rn/rd)
// Optional feature:
//   REG_FILE_BYPASS_EN  when defined, a read matching an enabled nonzero
//                       same-cycle write returns that write data
//                       combinationally (wd1 preferred over wd0).
// ---------------------------------------------------------------------------
module reg_file_mp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NRD    = 2
) (
   input  logic          clk,
   input  logic          reset,
   reg_file_mp_if.slave  bus
);
   localparam int                DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = {ADDR_W{1'b1}};
   localparam logic [ADDR_W-1:0] FIRST_PTR = ADDR_W'(1);

   typedef enum logic {S_CLEAR, S_IDLE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_clr_ptr;
   logic [ADDR_W-1:0]   w_clr_ptr_next;
   logic                w_clr_we;
   logic                w_ready;
   logic                w_wr0;
   logic                w_wr1;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_CLEAR;
         r_clr_ptr <= FIRST_PTR;
      end else begin
         r_state   <= w_state_next;
         r_clr_ptr <= w_clr_ptr_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next   = r_state;
      w_clr_ptr_next = r_clr_ptr;
      w_clr_we       = 1'b0;
      case (r_state)
         S_CLEAR: begin
            // Held off while reset is asserted so reset never touches the array.
            w_clr_we = !reset;
            // Stop on the last entry instead of wrapping the pointer into entry 0.
            if (r_clr_ptr == LAST_PTR)
               w_state_next = S_IDLE;
            else
               w_clr_ptr_next = r_clr_ptr + FIRST_PTR;
         end
         S_IDLE: begin
            if (bus.clear_req) begin
               w_state_next   = S_CLEAR;
               w_clr_ptr_next = FIRST_PTR;
            end
         end
         default: begin
            w_state_next   = S_CLEAR;
            w_clr_ptr_next = FIRST_PTR;
         end
      endcase
   end

   assign w_ready   = (r_state == S_IDLE);
   assign bus.ready = w_ready;

   // Port 0 is dropped when port 1 targets the same address in the same cycle.
   assign w_wr1 = w_ready && bus.we1 && (bus.wn1 != '0);
   assign w_wr0 = w_ready && bus.we0 && (bus.wn0 != '0) &&
                  !(bus.we1 && (bus.wn1 == bus.wn0));

   // Storage: no reset on the array; entry 0 is never written.
   always_ff @(posedge clk) begin
      if (w_clr_we) begin
         r_mem[r_clr_ptr] <= '0;
      end else begin
         if (w_wr0) r_mem[bus.wn0] <= bus.wd0;
         if (w_wr1) r_mem[bus.wn1] <= bus.wd1;
      end
   end

   // Independent combinational read ports
   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [ADDR_W-1:0] w_rn;
         logic [DATA_W-1:0] w_rd;

         assign w_rn = bus.rn[gi*ADDR_W +: ADDR_W];

         always_comb begin
            w_rd = '0;
            if (w_ready && (w_rn != '0)) begin
               w_rd = r_mem[w_rn];
`ifdef REG_FILE_BYPASS_EN
               // Forward the same-cycle write; port 1 has priority as in storage.
               if (bus.we1 && (bus.wn1 == w_rn))
                  w_rd = bus.wd1;
               else if (bus.we0 && (bus.wn0 == w_rn))
                  w_rd = bus.wd0;
`else
               // Stored value only; a same-cycle write shows after the posedge.
`endif
            end
         end

         assign bus.rd[gi*DATA_W +: DATA_W] = w_rd;
      end
   endgenerate
endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Directed checks of reg_file_mp at default parameters (32x32, two read ports).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns after
// the inputs settle, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NRD    = 2;

   logic clk;
   logic reset;
   int   errors;
   int   checks;
   int   n;

   reg_file_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) bus ();

   reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rn(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
      bus.rn = {a1, a0};
      #1;
   endtask

   // Counts edges until ready rises, bounded so a stuck DUT still ends the run.
   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (bus.ready !== 1'b1 && cnt < 200) begin
         step();
         cnt++;
      end
   endtask

   task automatic check_all_zero(input string tag);
      for (int i = 1; i < 32; i++) begin
         set_rn(ADDR_W'(i), ADDR_W'(32 - i));
         chk({tag, "_p0"}, bus.rd[0 +: DATA_W], 32'h0);
         chk({tag, "_p1"}, bus.rd[DATA_W +: DATA_W], 32'h0);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      bus.clear_req = 1'b0;
      bus.we0 = 1'b0; bus.wn0 = '0; bus.wd0 = '0;
      bus.we1 = 1'b0; bus.wn1 = '0; bus.wd1 = '0;
      bus.rn = '0;

      // 1: reset, then a 31-cycle clear
      repeat (3) @(posedge clk);
      #1;
      chk("ready_in_reset", 32'(bus.ready), 32'h0);
      reset = 1'b0;
      set_rn(5'd5, 5'd31);
      chk("rd_during_clear", bus.rd[0 +: DATA_W], 32'h0);
      wait_ready(n);
      chk("clear_len_reset", 32'(n), 32'd31);
      chk("ready_after_clear", 32'(bus.ready), 32'h1);
      check_all_zero("init_zero");

      // 2: single write then read, entry 0 reads zero
      bus.we0 = 1'b1; bus.wn0 = 5'd5; bus.wd0 = 32'hDEADBEEF;
      step();
      bus.we0 = 1'b0;
      set_rn(5'd5, 5'd0);
      chk("wr_rd_5", bus.rd[0 +: DATA_W], 32'hDEADBEEF);
      chk("rd_zero", bus.rd[DATA_W +: DATA_W], 32'h0);

      // 3: collision priority, write to entry 0, two distinct writes
      bus.we0 = 1'b1; bus.wn0 = 5'd7; bus.wd0 = 32'd1;
      bus.we1 = 1'b1; bus.wn1 = 5'd7; bus.wd1 = 32'd2;
      step();
      bus.we0 = 1'b0;
      bus.wn1 = 5'd0; bus.wd1 = 32'd9;
      step();
      bus.we1 = 1'b0;
      set_rn(5'd7, 5'd0);
      chk("collide_p1_wins", bus.rd[0 +: DATA_W], 32'd2);
      chk("wr0_ignored", bus.rd[DATA_W +: DATA_W], 32'h0);
      bus.we0 = 1'b1; bus.wn0 = 5'd10; bus.wd0 = 32'hA0A0A0A0;
      bus.we1 = 1'b1; bus.wn1 = 5'd11; bus.wd1 = 32'hB1B1B1B1;
      step();
      bus.we0 = 1'b0; bus.we1 = 1'b0;
      set_rn(5'd10, 5'd11);
      chk("dual_wr_p0", bus.rd[0 +: DATA_W], 32'hA0A0A0A0);
      chk("dual_wr_p1", bus.rd[DATA_W +: DATA_W], 32'hB1B1B1B1);

      // 4: read-during-write
      set_rn(5'd8, 5'd8);
      bus.we0 = 1'b1; bus.wn0 = 5'd8; bus.wd0 = 32'h55;
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("rdw_same_cycle_p0", bus.rd[0 +: DATA_W], 32'h55);
      chk("rdw_same_cycle_p1", bus.rd[DATA_W +: DATA_W], 32'h55);
`else
      chk("rdw_same_cycle_p0", bus.rd[0 +: DATA_W], 32'h0);
      chk("rdw_same_cycle_p1", bus.rd[DATA_W +: DATA_W], 32'h0);
`endif
      step();
      bus.we0 = 1'b0;
      #1;
      chk("rdw_next_cycle", bus.rd[0 +: DATA_W], 32'h55);
      set_rn(5'd9, 5'd0);
      bus.we0 = 1'b1; bus.wn0 = 5'd9; bus.wd0 = 32'hAA;
      bus.we1 = 1'b1; bus.wn1 = 5'd9; bus.wd1 = 32'hBB;
      #1;
`ifdef REG_FILE_BYPASS_EN
      chk("rdw_dual_same_cycle", bus.rd[0 +: DATA_W], 32'hBB);
`else
      chk("rdw_dual_same_cycle", bus.rd[0 +: DATA_W], 32'h0);
`endif
      bus.wn0 = 5'd0; bus.wn1 = 5'd0;
      #1;
      chk("no_bypass_addr0", bus.rd[DATA_W +: DATA_W], 32'h0);
      bus.wn0 = 5'd9; bus.wn1 = 5'd9;
      step();
      bus.we0 = 1'b0; bus.we1 = 1'b0;
      #1;
      chk("rdw_dual_next", bus.rd[0 +: DATA_W], 32'hBB);

      // 5: fill with index, clear on request, writes ignored while clearing
      for (int i = 1; i < 32; i++) begin
         bus.we0 = 1'b1; bus.wn0 = ADDR_W'(i); bus.wd0 = 32'(i);
         step();
      end
      bus.we0 = 1'b0;
      set_rn(5'd17, 5'd31);
      chk("fill_17", bus.rd[0 +: DATA_W], 32'd17);
      chk("fill_31", bus.rd[DATA_W +: DATA_W], 32'd31);
      bus.clear_req = 1'b1;
      bus.we0 = 1'b1; bus.wn0 = 5'd3; bus.wd0 = 32'd99;
      step();
      bus.clear_req = 1'b0;
      bus.wn0 = 5'd4; bus.wd0 = 32'h1234;
      #1;
      chk("ready_drop_on_req", 32'(bus.ready), 32'h0);
      chk("rd_zero_in_clear", bus.rd[0 +: DATA_W], 32'h0);
      wait_ready(n);
      bus.we0 = 1'b0;
      chk("clear_len_req", 32'(n), 32'd31);
      check_all_zero("req_zero");

      // 6: reset in the middle of a clear restarts it from entry 1
      bus.clear_req = 1'b1;
      step();
      bus.clear_req = 1'b0;
      repeat (10) step();
      reset = 1'b1;
      #1;
      chk("ready_mid_reset", 32'(bus.ready), 32'h0);
      step();
      step();
      reset = 1'b0;
      wait_ready(n);
      chk("clear_len_restart", 32'(n), 32'd31);
      chk("ready_after_restart", 32'(bus.ready), 32'h1);
      set_rn(5'd1, 5'd31);
      chk("restart_zero_1", bus.rd[0 +: DATA_W], 32'h0);
      chk("restart_zero_31", bus.rd[DATA_W +: DATA_W], 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
